// File: rtl/calc_arbiter_if.sv
// Request/response and core-handshake bundle for calc_arbiter.
// slave: the arbiter side. master: the clients plus the calculate core.
interface calc_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned IdW = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IdW-1:0]          rsp_id;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;

  logic                    calc_start;
  logic                    calc_done;
  logic                    calc_idle;
  logic                    calc_ready;
  logic [DATA_W-1:0]       calc_a;
  logic [DATA_W-1:0]       calc_b;
  logic [DATA_W-1:0]       calc_return;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    input  calc_done, calc_idle, calc_ready, calc_return,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    output calc_start, calc_a, calc_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    output calc_done, calc_idle, calc_ready, calc_return,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    input  calc_start, calc_a, calc_b
  );
endinterface

// File: rtl/calc_arbiter.sv
// Round-robin arbiter sharing one ap_ctrl_hs calculate core among N_REQ requesters.
// Define CALC_ARB_WATCHDOG_EN to abort ISSUE after TIMEOUT cycles without ap_done.
module calc_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input logic           ap_clk,
  input logic           ap_rst_n,
  calc_arbiter_if.slave bus
);
  localparam int unsigned IdW = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] calc_a_q, calc_a_d;
  logic [DATA_W-1:0] calc_b_q, calc_b_d;
  logic [IdW-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              grant_found;
  logic [IdW-1:0]    grant_idx;
  logic [IdW:0]      cand_sum;
  logic [IdW-1:0]    cand;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic              timeout_hit;

  // Search upward from rr_ptr with wrap; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IdW+1)'(k);
      if (cand_sum >= (IdW+1)'(N_REQ)) begin
        cand_sum = cand_sum - (IdW+1)'(N_REQ);
      end
      cand = cand_sum[IdW-1:0];
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_idx == IdW'(i)) begin
        sel_a = bus.req_a[i*DATA_W +: DATA_W];
        sel_b = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Gated by reset so no accept is advertised while the block is held in reset.
  always_comb begin
    bus.req_ready = '0;
    if (ap_rst_n && state_q == StIdle && grant_found) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

`ifdef CALC_ARB_WATCHDOG_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       rsp_err_q, rsp_err_d;

  // Counts ISSUE cycles already spent; zero on the first ISSUE cycle.
  always_comb begin
    wd_cnt_d = (state_q == StIssue) ? wd_cnt_q + 8'd1 : 8'd0;
  end

  assign timeout_hit = (wd_cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wd_cnt_q  <= 8'd0;
      rsp_err_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  logic [7:0] unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = 8'(TIMEOUT);
  assign bus.rsp_err    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    calc_a_d   = calc_a_q;
    calc_b_d   = calc_b_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
`ifdef CALC_ARB_WATCHDOG_EN
    rsp_err_d  = rsp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          calc_a_d = sel_a;
          calc_b_d = sel_b;
          rsp_id_d = grant_idx;
          rr_ptr_d = (grant_idx == IdW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        // ap_done takes priority over a simultaneous timeout.
        if (bus.calc_done) begin
          rsp_data_d = bus.calc_return;
`ifdef CALC_ARB_WATCHDOG_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = StResp;
        end else if (timeout_hit) begin
          rsp_data_d = '0;
`ifdef CALC_ARB_WATCHDOG_EN
          rsp_err_d  = 1'b1;
`endif
          state_d    = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      calc_a_q   <= '0;
      calc_b_q   <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      calc_a_q   <= calc_a_d;
      calc_b_q   <= calc_b_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // ap_idle / ap_ready are status only; completion is taken from ap_done.
  logic unused_status;
  assign unused_status = bus.calc_idle ^ bus.calc_ready;

  assign bus.calc_start = (state_q == StIssue);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.calc_a     = calc_a_q;
  assign bus.calc_b     = calc_b_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;

endmodule
